// File: rtl/sequential_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier and its BCD converter.
//   state_t      : top-level FSM encoding
//   BCD_STEPS    : double-dabble iterations (binary magnitude width)
//   OUT_W        : width of the binary and BCD result ports
//   booth_steps(): Booth iterations for a given packed input width
package sequential_multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    SIGN = 3'd2,
    BCD  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int BCD_STEPS = 10;
  localparam int OUT_W     = 12;

  function automatic int booth_steps(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sequential_multiplier_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per clock, BCD_STEPS cycles.
//   clk, rst : clock, synchronous active-low reset
//   start    : load bin and begin converting
//   clear    : drop done without touching the held bcd value
//   bin      : binary magnitude to convert
//   bcd      : {hundreds, tens, units}, updated on the final iteration
//   done     : level, set with bcd on the final iteration
//   last     : high during the cycle whose edge performs the final iteration
module bin2bcd_seq
  import sequential_multiplier_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [BCD_STEPS-1:0] bin,
  output logic [OUT_W-1:0]     bcd,
  output logic                 done,
  output logic                 last
);

  localparam int SR_W = OUT_W + BCD_STEPS;

  // {bcd nibbles, remaining binary bits}
  logic [SR_W-1:0] sr, sr_adj, sr_shift;
  logic [3:0]      cnt;
  logic            busy;

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < OUT_W / 4; i++) begin
      if (sr[BCD_STEPS + 4*i +: 4] >= 4'd5)
        sr_adj[BCD_STEPS + 4*i +: 4] = sr[BCD_STEPS + 4*i +: 4] + 4'd3;
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  assign last = busy && (cnt == 4'(BCD_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      if (clear) done <= 1'b0;
      if (start) begin
        sr   <= {{OUT_W{1'b0}}, bin};
        cnt  <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end else if (busy) begin
        sr  <= sr_shift;
        cnt <= cnt + 4'd1;
        if (last) begin
          bcd  <= sr_shift[SR_W-1:BCD_STEPS];
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sequential_multiplier.sv
// Sequential signed multiplier: radix-2 Booth, one step per clock, then
// sign/magnitude split and BCD conversion for the display driver.
//   clk, rst          : clock, synchronous active-low reset
//   enable            : start request (sampled in IDLE); must drop before restart
//   data              : {A, B}, each WIDTH/2-bit two's complement
//   neg               : product strictly negative
//   ready             : neg / out_final_results valid
//   ready_bcd         : bcd_d_out valid
//   out_final_results : |A*B| zero-extended
//   bcd_d_out         : |A*B| as {hundreds, tens, units}
module sequential_multiplier
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic             neg,
  output logic             ready,
  output logic             ready_bcd,
  output logic [OUT_W-1:0] out_final_results,
  output logic [OUT_W-1:0] bcd_d_out
);

  localparam int HW    = WIDTH / 2;
  localparam int STEPS = booth_steps(WIDTH);
  // {upper (HW+1), multiplier (HW)} forms the 11-bit product register; the
  // extra LSB is the Booth history bit. The spare upper bit keeps -16*-16 exact.
  localparam int AW    = WIDTH + 2;

  state_t          state, state_nx;
  logic [2:0]      cnt;
  logic [HW:0]     m;
  logic [AW-1:0]   acc, acc_step;
  logic [HW:0]     upper_nx;
  logic [WIDTH-1:0] p, mag;
  logic            bcd_start, bcd_clear, bcd_last;

  always_comb begin
    upper_nx = acc[AW-1:HW+1];
    case (acc[1:0])
      2'b01:   upper_nx = acc[AW-1:HW+1] + m;
      2'b10:   upper_nx = acc[AW-1:HW+1] - m;
      default: upper_nx = acc[AW-1:HW+1];
    endcase
    acc_step = {upper_nx[HW], upper_nx, acc[HW:1]};
  end

  assign p   = acc[WIDTH:1];
  assign mag = p[WIDTH-1] ? (~p + 1'b1) : p;

  assign bcd_start = (state == SIGN);
  assign bcd_clear = (state == IDLE) && enable;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (enable) state_nx = RUN;
      RUN:  if (cnt == 3'(STEPS - 1)) state_nx = SIGN;
      SIGN: state_nx = BCD;
      BCD:  if (bcd_last) state_nx = DONE;
      DONE: if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt               <= '0;
      m                 <= '0;
      acc               <= '0;
      neg               <= 1'b0;
      ready             <= 1'b0;
      out_final_results <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          m     <= {data[WIDTH-1], data[WIDTH-1:HW]};
          acc   <= {{(HW+1){1'b0}}, data[HW-1:0], 1'b0};
          cnt   <= '0;
          ready <= 1'b0;
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 3'd1;
        end
        SIGN: begin
          neg               <= p[WIDTH-1];
          out_final_results <= OUT_W'(mag);
          ready             <= 1'b1;
          cnt               <= '0;
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .clear (bcd_clear),
    .bin   (BCD_STEPS'(mag)),
    .bcd   (bcd_d_out),
    .done  (ready_bcd),
    .last  (bcd_last)
  );

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed self-checking bench for sequential_multiplier.
module tb_sequential_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  data;
  logic        neg, ready, ready_bcd;
  logic [11:0] out_final_results, bcd_d_out;

  int n_assert = 0;
  int n_fail   = 0;
  int drops;

  always #5 clk = ~clk;

  sequential_multiplier #(.WIDTH(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .data              (data),
    .neg               (neg),
    .ready             (ready),
    .ready_bcd         (ready_bcd),
    .out_final_results (out_final_results),
    .bcd_d_out         (bcd_d_out)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {11'b0, ready}, 12'h0);
    chk({tag, "_ready_bcd"}, {11'b0, ready_bcd}, 12'h0);
    chk({tag, "_neg"}, {11'b0, neg}, 12'h0);
    chk({tag, "_out"}, out_final_results, 12'h0);
    chk({tag, "_bcd"}, bcd_d_out, 12'h0);
  endtask

  // One-cycle enable pulse; data is scrambled after E0 to prove it is ignored.
  task automatic run_mult(input string tag, input logic [9:0] d, input logic en,
                          input logic [11:0] emag, input logic [11:0] ebcd);
    enable = 1'b1;
    data   = d;
    edge1();                       // E0
    enable = 1'b0;
    data   = ~d;
    chk({tag, "_ready_e0"}, {11'b0, ready}, 12'h0);
    chk({tag, "_rbcd_e0"}, {11'b0, ready_bcd}, 12'h0);
    repeat (5) edge1();            // E5
    chk({tag, "_ready_e5"}, {11'b0, ready}, 12'h0);
    edge1();                       // E6
    chk({tag, "_ready_e6"}, {11'b0, ready}, 12'h1);
    chk({tag, "_neg"}, {11'b0, neg}, {11'b0, en});
    chk({tag, "_mag"}, out_final_results, emag);
    repeat (9) edge1();            // E15
    chk({tag, "_rbcd_e15"}, {11'b0, ready_bcd}, 12'h0);
    edge1();                       // E16
    chk({tag, "_rbcd_e16"}, {11'b0, ready_bcd}, 12'h1);
    chk({tag, "_bcd"}, bcd_d_out, ebcd);
    repeat (2) edge1();            // DONE -> IDLE
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    data   = '0;
    repeat (2) edge1();
    chk_all_zero("reset");
    rst = 1'b1;
    edge1();

    run_mult("m3x8",    10'b11101_01000, 1'b1, 12'h018, 12'h024);
    run_mult("11x14",   10'b01011_01110, 1'b0, 12'h09A, 12'h154);
    run_mult("m16x15",  10'b10000_01111, 1'b1, 12'h0F0, 12'h240);
    run_mult("m16xm16", 10'b10000_10000, 1'b0, 12'h100, 12'h256);
    run_mult("0xm11",   10'b00000_10101, 1'b0, 12'h000, 12'h000);

    // Held enable: one computation only, ready never drops once set.
    enable = 1'b1;
    data   = 10'b01011_01110;
    edge1();                       // E0
    drops = 0;
    for (int i = 1; i <= 30; i++) begin
      edge1();
      if (i >= 6 && ready !== 1'b1) drops++;
    end
    chk("hold_drops", 12'(drops), 12'h0);
    chk("hold_mag", out_final_results, 12'h09A);
    chk("hold_bcd", bcd_d_out, 12'h154);
    chk("hold_rbcd", {11'b0, ready_bcd}, 12'h1);
    enable = 1'b0;
    edge1();                       // DONE sees enable low -> IDLE
    run_mult("after_hold", 10'b11101_01000, 1'b1, 12'h018, 12'h024);

    // Reset mid-run at E3.
    enable = 1'b1;
    data   = 10'b10000_01111;
    edge1();                       // E0
    enable = 1'b0;
    repeat (2) edge1();            // E2
    rst = 1'b0;
    edge1();                       // E3
    chk_all_zero("midrst");
    rst = 1'b1;
    repeat (12) edge1();
    chk_all_zero("midrst_idle");
    run_mult("post_rst", 10'b10000_10000, 1'b0, 12'h100, 12'h256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
